// File: rtl/p1_auto_player.sv
// -----------------------------------------------------------------------------
// p1_auto_player
//
// Automated Player 1 agent. It sits on the player side of the game core's P1
// move interface. When the core raises 'turn', it snapshots the P1 hand and the
// table card. It then scans the hand one slot per clock and answers with the
// cheapest winning card, or with a pass if no card wins.
//
// Ports:
//   clka        in   system clock, rising edge
//   restart     in   synchronous active-high reset, highest priority
//   turn        in   level, high while the core waits for a P1 move
//   hand        in   NUM_SLOTS*CARD_W P1 hand, slot i = hand[CARD_W*i +: CARD_W]
//   max_card    in   current top card, 0 = empty table
//   p1_decision out  selected slot, 1-based; 0 = none
//   p1_no       out  pass request
//   move_valid  out  high while p1_decision/p1_no carry a decided move
//   busy        out  high in SCAN and DECIDE
//
// Optional build macro P1_BOT_STATS_EN adds the saturating 8-bit counters
// plays_cnt and pass_cnt. Each counts one DECIDE outcome.
// -----------------------------------------------------------------------------
module p1_auto_player #(
    parameter int NUM_SLOTS = 4,
    parameter int CARD_W    = 6,
    parameter int DEC_W     = 3
) (
    input  logic                        clka,
    input  logic                        restart,
    input  logic                        turn,
    input  logic [NUM_SLOTS*CARD_W-1:0] hand,
    input  logic [CARD_W-1:0]           max_card,
    output logic [DEC_W-1:0]            p1_decision,
    output logic                        p1_no,
    output logic                        move_valid,
    output logic                        busy
`ifdef P1_BOT_STATS_EN
    ,
    output logic [7:0]                  plays_cnt,
    output logic [7:0]                  pass_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, SCAN, DECIDE, HOLD, WAIT_LOW} state_t;

    state_t                      state_q, state_d;
    logic [NUM_SLOTS*CARD_W-1:0] hand_q, hand_d;
    logic [CARD_W-1:0]           maxCard_q, maxCard_d;
    logic [DEC_W-1:0]            idx_q, idx_d;
    logic [CARD_W-1:0]           card_q, card_d;
    logic [DEC_W-1:0]            cardIdx_q, cardIdx_d;
    logic                        cardVld_q, cardVld_d;
    logic                        bestVld_q, bestVld_d;
    logic [CARD_W-1:0]           bestCard_q, bestCard_d;
    logic [DEC_W-1:0]            bestIdx_q, bestIdx_d;
    logic [DEC_W-1:0]            decision_q, decision_d;
    logic                        no_q, no_d;
    logic                        valid_q, valid_d;
    logic                        busy_q, busy_d;
    logic                        exited_q, exited_d;
    logic [CARD_W-1:0]           fetchCard;

    // Slot mux over the latched hand. Its output is registered into card_q
    // and compared one edge later. Together with the DECIDE edge, this gives
    // NUM_SLOTS+2 edges from the turn sample to move_valid.
    always_comb begin
        fetchCard = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (idx_q == DEC_W'(i)) begin
                fetchCard = hand_q[CARD_W*i +: CARD_W];
            end
        end
    end

    // Next-state and output logic. exited_q remembers that the previous edge
    // left HOLD. A turn that is still high on the very next edge goes to
    // WAIT_LOW and does not start a second move.
    always_comb begin
        state_d    = state_q;
        hand_d     = hand_q;
        maxCard_d  = maxCard_q;
        idx_d      = idx_q;
        card_d     = card_q;
        cardIdx_d  = cardIdx_q;
        cardVld_d  = cardVld_q;
        bestVld_d  = bestVld_q;
        bestCard_d = bestCard_q;
        bestIdx_d  = bestIdx_q;
        decision_d = decision_q;
        no_d       = no_q;
        valid_d    = valid_q;
        exited_d   = exited_q;

        case (state_q)
            IDLE: begin
                exited_d = 1'b0;
                if (turn) begin
                    if (exited_q) begin
                        state_d = WAIT_LOW;
                    end else begin
                        hand_d     = hand;
                        maxCard_d  = max_card;
                        idx_d      = '0;
                        cardVld_d  = 1'b0;
                        bestVld_d  = 1'b0;
                        bestCard_d = '0;
                        bestIdx_d  = '0;
                        state_d    = SCAN;
                    end
                end
            end
            SCAN: begin
                if (!turn) begin
                    state_d = IDLE;
                end else begin
                    // A strict compare is enough because the deck has no
                    // duplicate ranks.
                    if (cardVld_q && (card_q != '0) && (card_q > maxCard_q) &&
                        (!bestVld_q || (card_q < bestCard_q))) begin
                        bestVld_d  = 1'b1;
                        bestCard_d = card_q;
                        bestIdx_d  = cardIdx_q;
                    end
                    if (idx_q < DEC_W'(NUM_SLOTS)) begin
                        card_d    = fetchCard;
                        cardIdx_d = idx_q;
                        cardVld_d = 1'b1;
                        idx_d     = idx_q + DEC_W'(1);
                    end else begin
                        cardVld_d = 1'b0;
                        state_d   = DECIDE;
                    end
                end
            end
            DECIDE: begin
                if (!turn) begin
                    state_d = IDLE;
                end else begin
                    valid_d = 1'b1;
                    if (bestVld_q) begin
                        decision_d = bestIdx_q + DEC_W'(1);
                        no_d       = 1'b0;
                    end else begin
                        decision_d = '0;
                        no_d       = 1'b1;
                    end
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!turn) begin
                    decision_d = '0;
                    no_d       = 1'b0;
                    valid_d    = 1'b0;
                    exited_d   = 1'b1;
                    state_d    = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!turn) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SCAN) || (state_d == DECIDE);
    end

    // State and output registers. restart overrides everything.
    always_ff @(posedge clka) begin
        if (restart) begin
            state_q    <= IDLE;
            hand_q     <= '0;
            maxCard_q  <= '0;
            idx_q      <= '0;
            card_q     <= '0;
            cardIdx_q  <= '0;
            cardVld_q  <= 1'b0;
            bestVld_q  <= 1'b0;
            bestCard_q <= '0;
            bestIdx_q  <= '0;
            decision_q <= '0;
            no_q       <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            exited_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hand_q     <= hand_d;
            maxCard_q  <= maxCard_d;
            idx_q      <= idx_d;
            card_q     <= card_d;
            cardIdx_q  <= cardIdx_d;
            cardVld_q  <= cardVld_d;
            bestVld_q  <= bestVld_d;
            bestCard_q <= bestCard_d;
            bestIdx_q  <= bestIdx_d;
            decision_q <= decision_d;
            no_q       <= no_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            exited_q   <= exited_d;
        end
    end

    assign p1_decision = decision_q;
    assign p1_no       = no_q;
    assign move_valid  = valid_q;
    assign busy        = busy_q;

`ifdef P1_BOT_STATS_EN
    logic [7:0] playsCnt_q;
    logic [7:0] passCnt_q;

    // Each completed DECIDE bumps exactly one of the counters. Both counters
    // stick at 255.
    always_ff @(posedge clka) begin
        if (restart) begin
            playsCnt_q <= '0;
            passCnt_q  <= '0;
        end else if ((state_q == DECIDE) && turn) begin
            if (bestVld_q) begin
                if (playsCnt_q != 8'hFF) playsCnt_q <= playsCnt_q + 8'd1;
            end else begin
                if (passCnt_q != 8'hFF) passCnt_q <= passCnt_q + 8'd1;
            end
        end
    end

    assign plays_cnt = playsCnt_q;
    assign pass_cnt  = passCnt_q;
`endif

endmodule

// File: tb/tb_p1_auto_player.sv
// -----------------------------------------------------------------------------
// tb_p1_auto_player
//
// Directed testbench for p1_auto_player. Inputs change 1 time unit after a
// rising edge, and outputs are sampled at that same point. Every expected
// value is a hand-worked constant. The counter checks are built only when
// P1_BOT_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_p1_auto_player;

    logic        clka = 1'b0;
    logic        restart;
    logic        turn;
    logic [23:0] hand;
    logic [5:0]  max_card;
    logic [2:0]  p1_decision;
    logic        p1_no;
    logic        move_valid;
    logic        busy;
`ifdef P1_BOT_STATS_EN
    logic [7:0]  plays_cnt;
    logic [7:0]  pass_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    p1_auto_player dut (
        .clka        (clka),
        .restart     (restart),
        .turn        (turn),
        .hand        (hand),
        .max_card    (max_card),
        .p1_decision (p1_decision),
        .p1_no       (p1_no),
        .move_valid  (move_valid),
        .busy        (busy)
`ifdef P1_BOT_STATS_EN
        ,
        .plays_cnt   (plays_cnt),
        .pass_cnt    (pass_cnt)
`endif
    );

    // 10 time-unit clock.
    always #5 clka = ~clka;

    // Advance one rising edge, then settle to the sample/drive point.
    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Apply one input vector. Slot order is s0 (low bits) to s3.
    task automatic applyStimulus(input logic [5:0] s0, input logic [5:0] s1,
                                 input logic [5:0] s2, input logic [5:0] s3,
                                 input logic [5:0] mc, input logic t);
        hand     = {s3, s2, s1, s0};
        max_card = mc;
        turn     = t;
    endtask

    // Raise turn with the given hand and check the exact latency: move_valid
    // is still low after edge k+5 and high after edge k+6. The DUT ends in HOLD.
    task automatic runMove(input string tag, input logic [5:0] s0, input logic [5:0] s1,
                           input logic [5:0] s2, input logic [5:0] s3, input logic [5:0] mc,
                           input logic [2:0] expDec, input logic expNo);
        applyStimulus(s0, s1, s2, s3, mc, 1'b1);
        tick();
        checkOutput({tag, ".busy_scan"}, busy, 1);
        repeat (5) tick();
        checkOutput({tag, ".valid_early"}, move_valid, 0);
        tick();
        checkOutput({tag, ".valid"}, move_valid, 1);
        checkOutput({tag, ".decision"}, p1_decision, expDec);
        checkOutput({tag, ".no"}, p1_no, expNo);
        checkOutput({tag, ".busy_hold"}, busy, 0);
    endtask

    // Drop turn to leave HOLD. The extra edge lets the exit guard clear.
    task automatic releaseTurn(input string tag);
        turn = 1'b0;
        tick();
        checkOutput({tag, ".rel_valid"}, move_valid, 0);
        checkOutput({tag, ".rel_decision"}, p1_decision, 0);
        checkOutput({tag, ".rel_no"}, p1_no, 0);
        tick();
    endtask

    initial begin
        $display("[TB] start");
        restart = 1'b1;
        applyStimulus(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
        tick();
        tick();
        restart = 1'b0;
        checkOutput("reset.decision", p1_decision, 0);
        checkOutput("reset.no", p1_no, 0);
        checkOutput("reset.valid", move_valid, 0);
        checkOutput("reset.busy", busy, 0);

        // Cheapest winner over 15 is 18 in slot 2.
        runMove("basic", 6'd10, 6'd25, 6'd18, 6'd40, 6'd15, 3'd3, 1'b0);
        tick();
        tick();
        checkOutput("hold.valid", move_valid, 1);
        checkOutput("hold.decision", p1_decision, 3);
        releaseTurn("basic");

        runMove("pass", 6'd5, 6'd7, 6'd0, 6'd12, 6'd12, 3'd0, 1'b1);
        releaseTurn("pass");
        runMove("empty_table", 6'd0, 6'd33, 6'd9, 6'd0, 6'd0, 3'd3, 1'b0);
        releaseTurn("empty_table");
        runMove("all_empty", 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b1);
        releaseTurn("all_empty");
        runMove("max63", 6'd10, 6'd20, 6'd30, 6'd40, 6'd63, 3'd0, 1'b1);
        releaseTurn("max63");
        runMove("slot2", 6'd50, 6'd45, 6'd60, 6'd47, 6'd44, 3'd2, 1'b0);
        releaseTurn("slot2");
        runMove("slot4", 6'd0, 6'd0, 6'd0, 6'd62, 6'd61, 3'd4, 1'b0);
        releaseTurn("slot4");
        runMove("slot1", 6'd20, 6'd30, 6'd40, 6'd50, 6'd0, 3'd1, 1'b0);
        releaseTurn("slot1");

        // Abort: turn is sampled high at k..k+2 and low at k+3.
        applyStimulus(6'd10, 6'd25, 6'd18, 6'd40, 6'd15, 1'b1);
        tick();
        tick();
        tick();
        turn = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            checkOutput("abort.valid", move_valid, 0);
            tick();
        end
        checkOutput("abort.busy", busy, 0);

        // The latched hand wins over a hand that changes after edge k.
        applyStimulus(6'd10, 6'd25, 6'd18, 6'd40, 6'd15, 1'b1);
        tick();
        applyStimulus(6'd1, 6'd2, 6'd3, 6'd4, 6'd0, 1'b1);
        repeat (6) tick();
        checkOutput("latch.valid", move_valid, 1);
        checkOutput("latch.decision", p1_decision, 3);
        releaseTurn("latch");

        // Glitch guard: turn is low for exactly one edge after HOLD. The DUT
        // parks in WAIT_LOW and must not make a second move.
        runMove("glitch_pre", 6'd10, 6'd25, 6'd18, 6'd40, 6'd15, 3'd3, 1'b0);
        turn = 1'b0;
        tick();
        turn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("glitch.valid", move_valid, 0);
            checkOutput("glitch.busy", busy, 0);
        end
        turn = 1'b0;
        tick();
        tick();
        runMove("glitch_post", 6'd50, 6'd45, 6'd60, 6'd47, 6'd44, 3'd2, 1'b0);

        // Restart while in HOLD, with turn still high.
        restart = 1'b1;
        tick();
        checkOutput("rst_hold.decision", p1_decision, 0);
        checkOutput("rst_hold.no", p1_no, 0);
        checkOutput("rst_hold.valid", move_valid, 0);
        checkOutput("rst_hold.busy", busy, 0);
        restart = 1'b0;
        turn    = 1'b0;
        tick();
        runMove("after_rst", 6'd0, 6'd33, 6'd9, 6'd0, 6'd0, 3'd3, 1'b0);
        releaseTurn("after_rst");

`ifdef P1_BOT_STATS_EN
        restart = 1'b1;
        turn    = 1'b0;
        tick();
        restart = 1'b0;
        checkOutput("stats.rst_plays", plays_cnt, 0);
        checkOutput("stats.rst_pass", pass_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            runMove("stats_play", 6'd10, 6'd25, 6'd18, 6'd40, 6'd15, 3'd3, 1'b0);
            releaseTurn("stats_play");
        end
        for (int i = 0; i < 2; i++) begin
            runMove("stats_pass", 6'd5, 6'd7, 6'd0, 6'd12, 6'd12, 3'd0, 1'b1);
            releaseTurn("stats_pass");
        end
        checkOutput("stats.plays3", plays_cnt, 3);
        checkOutput("stats.pass2", pass_cnt, 2);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(6'd10, 6'd25, 6'd18, 6'd40, 6'd15, 1'b1);
            repeat (7) tick();
            turn = 1'b0;
            tick();
            tick();
        end
        checkOutput("stats.plays_sat", plays_cnt, 255);
        checkOutput("stats.pass_hold", pass_cnt, 2);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checkOutput("stats.clr_plays", plays_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/p1_auto_player.md
Name: p1_auto_player

Overview:
- Automated Player 1 agent. It sits on the player side of the game core's P1 move interface and is the counterpart to the core.
- It consumes the core's P1 hand image (P1_out) and the current table card (max_card).
- It produces the P1 move inputs the core expects: the slot select (P1_decision) and the pass flag (P1_no).
- It replaces manual switches for self-play and regression runs.

Parameters:
NUM_SLOTS, 4, hand slots scanned; hand bus width is NUM_SLOTS*CARD_W
CARD_W, 6, bits per card code; 0 = empty slot, 1..63 = card rank, larger wins
DEC_W, 3, width of the slot-select output; must hold NUM_SLOTS

Ports:
clka  in  1  system clock, rising edge
restart  in  1  synchronous, active-high reset
turn  in  1  level; high while the core waits for a P1 move
hand  in  NUM_SLOTS*CARD_W  P1 hand; slot i = hand[CARD_W*i +: CARD_W]
max_card  in  CARD_W  current top card; 0 = empty table
p1_decision  out  DEC_W  selected slot, 1-based (1..NUM_SLOTS); 0 = none
p1_no  out  1  pass request
move_valid  out  1  high while p1_decision/p1_no carry a decided move
busy  out  1  high in SCAN and DECIDE

Behaviour:
- Reset: on restart sampled high at a clka edge, all outputs go to 0 and the state goes to IDLE. Restart has priority over every other event, including mid-scan and HOLD. All outputs are registered.
- States: IDLE, SCAN, DECIDE, HOLD, WAIT_LOW.
- IDLE: on an edge with turn=1:
  - latch hand and max_card into internal copies;
  - clear the index to 0 and best to none;
  - go to SCAN.
  Later changes to hand or max_card do not affect the current move.
- SCAN: one slot per edge, index 0..NUM_SLOTS-1. A slot is a candidate if card != 0 and card > latched max_card (unsigned). Best is replaced when the candidate is < the current best card, or when best is none. After the last slot, go to DECIDE.
- DECIDE (one edge):
  - if best exists: p1_decision = best index + 1, p1_no = 0;
  - otherwise: p1_decision = 0, p1_no = 1;
  - move_valid = 1; go to HOLD.
- Latency: turn sampled at edge k gives move_valid = 1 after edge k+NUM_SLOTS+2 (k+6 at defaults).
- HOLD: outputs stay stable while turn=1. On an edge with turn=0, clear p1_decision, p1_no and move_valid to 0, then go to IDLE.
- Turn dropping during SCAN or DECIDE: abort to IDLE with no move; outputs stay 0; move_valid never pulses.
- Re-arm is level-based. A new move requires turn to pass through IDLE, so one HOLD exit equals one move.
- WAIT_LOW: entered from IDLE only if turn is still high on the edge immediately after a HOLD exit (same-cycle glitch guard). Leaves to IDLE when turn=0. This prevents a double move when turn toggles for exactly one cycle.
- Boundary cases:
  - all slots empty: pass;
  - max_card = 63: pass;
  - max_card = 0: play the smallest non-zero card;
  - equal card values are impossible (unique deck), so a strict compare is sufficient.
- busy = 1 exactly in SCAN and DECIDE.

Optional Feature:
- Macro: P1_BOT_STATS_EN.
- When defined, two extra outputs are added:
  - plays_cnt [7:0]: increments on each DECIDE with a play;
  - pass_cnt [7:0]: increments on each DECIDE with a pass.
  - Both saturate at 255 and are cleared by restart.
- When not defined, these ports and their logic are absent and the behaviour is otherwise identical.

Test Plan:
- Basic play: restart 2 cycles; hand slots {0:10, 1:25, 2:18, 3:40}, max_card=15, turn=1 → move_valid=1 six edges later; p1_decision=3 (card 18), p1_no=0.
- Forced pass: hand {5, 7, 0, 12}, max_card=12, turn=1 → p1_decision=0, p1_no=1, move_valid=1.
- Empty table: hand {0, 33, 9, 0}, max_card=0 → p1_decision=3. Then hand all zero → p1_no=1.
- Abort and latch: turn drops at edge k+3 → move_valid stays 0, return to IDLE. Separately, changing hand during SCAN → decision still reflects the hand latched at edge k.
- Restart mid-HOLD: move_valid=1, restart=1 → next edge all outputs 0 and state IDLE. A fresh turn then yields a correct move after 6 edges.
- Stats (P1_BOT_STATS_EN defined): 3 plays and 2 passes → plays_cnt=3, pass_cnt=2. Run 300 plays → plays_cnt saturates at 255.
